// File: rtl/muldiv_pkg.sv
// Shared encodings for the Execute-stage multiply/divide unit.
// Imported by the unit, its arithmetic core and its interface.
package muldiv_pkg;

    localparam int OP_W  = 3;
    localparam int CNT_W = 4;

    typedef enum logic [OP_W-1:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/e_muldiv_unit_if.sv
// Launch bundle from the E stage into the mul/div unit, and the
// busy/HI/LO view returned to the pipeline.
interface e_muldiv_unit_if;
    import muldiv_pkg::*;

    logic            start;
    logic [OP_W-1:0] op;
    logic [31:0]     rs_data;
    logic [31:0]     rt_data;
    logic            busy;
    logic [31:0]     hi;
    logic [31:0]     lo;

    modport master (
        output start, op, rs_data, rt_data,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data,
        output busy, hi, lo
    );

endinterface

// File: rtl/e_muldiv_arith.sv
// Combinational 64-bit mul/div result; one shared unsigned divider
// serves DIV and DIVU, with signs restored after the divide.
module e_muldiv_arith
    import muldiv_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [63:0] res,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        is_sdiv;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] q_s;
    logic [31:0] r_s;

    always_comb begin
        prod_s = $signed({{32{rs_data[31]}}, rs_data})
               * $signed({{32{rt_data[31]}}, rt_data});
        prod_u = {32'd0, rs_data} * {32'd0, rt_data};

        is_sdiv = (op == MD_DIV);
        neg_a   = is_sdiv & rs_data[31];
        neg_b   = is_sdiv & rt_data[31];
        mag_a   = neg_a ? (32'd0 - rs_data) : rs_data;
        mag_b   = neg_b ? (32'd0 - rt_data) : rt_data;

        // Divide-by-zero result is never committed; keep the divider defined.
        div_by_zero = (op == MD_DIV || op == MD_DIVU) && (rt_data == 32'd0);
        q_u = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
        r_u = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;

        // 0x80000000 / -1 wraps back to 0x80000000 through the negate.
        q_s = (neg_a ^ neg_b) ? (32'd0 - q_u) : q_u;
        r_s = neg_a ? (32'd0 - r_u) : r_u;

        res = 64'd0;
        unique case (op)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV:   res = {r_s, q_s};
            MD_DIVU:  res = {r_u, q_u};
            default:  res = 64'd0;
        endcase
    end

endmodule

// File: rtl/e_muldiv_unit.sv
// Execute-stage multi-cycle multiply/divide unit owning HI/LO.
// A launched mult/div always runs to completion unless reset.
module e_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic          clk,
    input  logic          reset,
    e_muldiv_unit_if.slave md
);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      res_q, res_d;
    logic             dz_q, dz_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    md_op_t      op_c;
    logic [63:0] arith_res;
    logic        arith_dz;
    logic        is_mul;
    logic        is_div;
    logic        is_mthi;
    logic        is_mtlo;

    assign op_c    = md_op_t'(md.op);
    assign is_mul  = (op_c == MD_MULT) || (op_c == MD_MULTU);
    assign is_div  = (op_c == MD_DIV) || (op_c == MD_DIVU);
    assign is_mthi = (op_c == MD_MTHI);
    assign is_mtlo = (op_c == MD_MTLO);

    e_muldiv_arith u_arith (
        .op          (op_c),
        .rs_data     (md.rs_data),
        .rt_data     (md.rt_data),
        .res         (arith_res),
        .div_by_zero (arith_dz)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (md.start) begin
                    unique case (1'b1)
                        is_mthi: hi_d = md.rs_data;
                        is_mtlo: lo_d = md.rs_data;
                        is_mul, is_div: begin
                            state_d = ST_BUSY;
                            res_d   = arith_res;
                            dz_d    = arith_dz;
                            cnt_d   = is_mul ? CNT_W'(MUL_CYCLES)
                                             : CNT_W'(DIV_CYCLES);
                        end
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                // start is ignored here; HI/LO only move on the final edge.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (!dz_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    assign md.busy = (state_q == ST_BUSY);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule
